// File: rtl/mul_issue_sched_pkg.sv
// Shared core definitions for the multiply/divide issue scheduler.
// Holds the op-class decode and the divider stall threshold default.
package mul_issue_sched_pkg;

  localparam int DIV_STALL_DEF = 40;
  localparam int CTL_CLS_HI    = 5;
  localparam int CTL_CLS_LO    = 0;

  // Divide ops carry zeros in both class bits; all else is mul/bitop.
  function automatic logic is_div(input logic c_hi, input logic c_lo);
    return !c_hi && !c_lo;
  endfunction

endpackage

// File: rtl/mul_issue_sched_rr_pick.sv
// Round-robin picker: first requester at or after the pointer wins.
// Grant is one-hot, or all-zero when nothing requests.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_issue_sched.sv
// Issue scheduler feeding the shared multiply/divide unit from
// per-requester one-entry buffers, with divider back-pressure.
module mul_issue_sched
  import mul_issue_sched_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int RV         = 64,
  parameter int CNTRL_SIZE = 7,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int NHART      = 1,
  parameter int LNHART     = 0,
  parameter int DIV_STALL  = DIV_STALL_DEF,
  localparam int HW  = (NHART == 1) ? 1 : LNHART,
  localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ-1:0][CNTRL_SIZE-1:0]  req_control,
  input  logic [NREQ-1:0][LNCOMMIT-1:0]    req_rd,
  input  logic [NREQ-1:0]                  req_makes_rd,
  input  logic [NREQ-1:0][HW-1:0]          req_hart,
  input  logic [NREQ-1:0][RV-1:0]          req_r1,
  input  logic [NREQ-1:0][RV-1:0]          req_r2,
  input  logic [NCOMMIT-1:0]               commit_kill_0,
  input  logic                             divide_busy,
  output logic                             mul_enable,
  output logic [CNTRL_SIZE-1:0]            mul_control,
  output logic [LNCOMMIT-1:0]              mul_rd,
  output logic                             mul_makes_rd,
  output logic [HW-1:0]                    mul_hart,
  output logic [RV-1:0]                    mul_r1,
  output logic [RV-1:0]                    mul_r2
);

  localparam int CW = $clog2(DIV_STALL + 1);
  localparam logic [CW-1:0] STALL = CW'(DIV_STALL);

  logic [NREQ-1:0]       v_q;
  logic [CNTRL_SIZE-1:0] ctl_q  [NREQ];
  logic [LNCOMMIT-1:0]   rd_q   [NREQ];
  logic [NREQ-1:0]       mrd_q;
  logic [HW-1:0]         hart_q [NREQ];
  logic [RV-1:0]         r1_q   [NREQ];
  logic [RV-1:0]         r2_q   [NREQ];

  logic [RRW-1:0] rr_q;
  logic           shadow_q;
  logic [CW-1:0]  cnt_q;
  logic [RV-1:0]  op1_q, op2_q;

  logic [NREQ-1:0] kill, dv, elig, gnt;
  logic            div_blk, mul_blk, any;
  logic [RRW-1:0]  win_idx, rr_d;
  logic            win_div;
  logic [CNTRL_SIZE-1:0] win_ctl;
  logic [LNCOMMIT-1:0]   win_rd;
  logic                  win_mrd;
  logic [HW-1:0]         win_hart;
  logic [RV-1:0]         win_r1, win_r2;

  assign div_blk = divide_busy | shadow_q;
  assign mul_blk = (cnt_q == STALL);

  always_comb begin
    kill = '0;
    dv   = '0;
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      kill[i] = v_q[i] & commit_kill_0[rd_q[i]];
      dv[i]   = is_div(ctl_q[i][CTL_CLS_HI], ctl_q[i][CTL_CLS_LO]);
      elig[i] = v_q[i] & ~kill[i] & (dv[i] ? ~div_blk : ~mul_blk);
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .PW   (RRW)
  ) u_pick (
    .req_i (elig),
    .ptr_i (rr_q),
    .gnt_o (gnt)
  );

  always_comb begin
    any      = |gnt;
    win_idx  = '0;
    win_div  = 1'b0;
    win_ctl  = '0;
    win_rd   = '0;
    win_mrd  = 1'b0;
    win_hart = '0;
    win_r1   = '0;
    win_r2   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_idx  = RRW'(i);
        win_div  = dv[i];
        win_ctl  = ctl_q[i];
        win_rd   = rd_q[i];
        win_mrd  = mrd_q[i];
        win_hart = hart_q[i];
        win_r1   = r1_q[i];
        win_r2   = r2_q[i];
      end
    end
    rr_d = (win_idx == RRW'(NREQ - 1)) ? '0 : win_idx + RRW'(1);
  end

  // A dropped or granted entry frees its slot in the same cycle.
  assign req_ready = ~v_q | gnt | kill;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q   <= '0;
      mrd_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        ctl_q[i]  <= '0;
        rd_q[i]   <= '0;
        hart_q[i] <= '0;
        r1_q[i]   <= '0;
        r2_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          v_q[i]    <= 1'b1;
          ctl_q[i]  <= req_control[i];
          rd_q[i]   <= req_rd[i];
          mrd_q[i]  <= req_makes_rd[i];
          hart_q[i] <= req_hart[i];
          r1_q[i]   <= req_r1[i];
          r2_q[i]   <= req_r2[i];
        end else if (gnt[i] || kill[i]) begin
          v_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q         <= '0;
      shadow_q     <= 1'b0;
      cnt_q        <= '0;
      mul_enable   <= 1'b0;
      mul_control  <= '0;
      mul_rd       <= '0;
      mul_makes_rd <= 1'b0;
      mul_hart     <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      mul_r1       <= '0;
      mul_r2       <= '0;
    end else begin
      shadow_q   <= any & win_div;
      mul_enable <= any;
      if (!divide_busy)      cnt_q <= '0;
      else if (cnt_q != STALL) cnt_q <= cnt_q + CW'(1);
      if (any) begin
        rr_q         <= rr_d;
        mul_control  <= win_ctl;
        mul_rd       <= win_rd;
        mul_makes_rd <= win_mrd;
        mul_hart     <= win_hart;
        op1_q        <= win_r1;
        op2_q        <= win_r2;
      end
      // Operands trail the issue fields by one cycle.
      if (mul_enable) begin
        mul_r1 <= op1_q;
        mul_r2 <= op2_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_sched.sv
// Randomized bench for mul_issue_sched against a cycle-level
// reference model of the buffer/arbitration rules.
module tb_mul_issue_sched;

  localparam int N  = 2;
  localparam int RV = 64;
  localparam int CS = 7;
  localparam int NC = 32;
  localparam int LC = 5;
  localparam int HW = 1;
  localparam int DS = 40;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][CS-1:0]  req_control;
  logic [N-1:0][LC-1:0]  req_rd;
  logic [N-1:0]          req_makes_rd;
  logic [N-1:0][HW-1:0]  req_hart;
  logic [N-1:0][RV-1:0]  req_r1;
  logic [N-1:0][RV-1:0]  req_r2;
  logic [NC-1:0]         commit_kill_0;
  logic                  divide_busy;
  logic                  mul_enable;
  logic [CS-1:0]         mul_control;
  logic [LC-1:0]         mul_rd;
  logic                  mul_makes_rd;
  logic [HW-1:0]         mul_hart;
  logic [RV-1:0]         mul_r1;
  logic [RV-1:0]         mul_r2;

  mul_issue_sched dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_control   (req_control),
    .req_rd        (req_rd),
    .req_makes_rd  (req_makes_rd),
    .req_hart      (req_hart),
    .req_r1        (req_r1),
    .req_r2        (req_r2),
    .commit_kill_0 (commit_kill_0),
    .divide_busy   (divide_busy),
    .mul_enable    (mul_enable),
    .mul_control   (mul_control),
    .mul_rd        (mul_rd),
    .mul_makes_rd  (mul_makes_rd),
    .mul_hart      (mul_hart),
    .mul_r1        (mul_r1),
    .mul_r2        (mul_r2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CS-1:0] ctl;
    logic [LC-1:0] rd;
    logic          mrd;
    logic [HW-1:0] hart;
    logic [RV-1:0] r1;
    logic [RV-1:0] r2;
  } op_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  op_t  mb [N];
  bit   mv [N];
  int   rr, busy_run, last_div;
  bit   prev_g;
  logic [RV-1:0] prev_r1, prev_r2;
  bit   e_en;
  op_t  e_op;
  logic [RV-1:0] e_r1, e_r2;
  int   busy_left;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit op_div(input op_t o);
    return (o.ctl[5] == 1'b0) && (o.ctl[0] == 1'b0);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      mv[j] = 0;
      mb[j] = '0;
    end
    rr       = 0;
    busy_run = 0;
    last_div = -100;
    prev_g   = 0;
    prev_r1  = '0;
    prev_r2  = '0;
    e_en     = 0;
    e_op     = '0;
    e_r1     = '0;
    e_r2     = '0;
  endtask

  task automatic check_outs();
    chk("mul_enable", {63'd0, mul_enable}, {63'd0, e_en});
    if (e_en) begin
      chk("mul_control", {57'd0, mul_control}, {57'd0, e_op.ctl});
      chk("mul_rd", {59'd0, mul_rd}, {59'd0, e_op.rd});
      chk("mul_makes_rd", {63'd0, mul_makes_rd}, {63'd0, e_op.mrd});
      chk("mul_hart", {63'd0, mul_hart}, {63'd0, e_op.hart});
    end
    chk("mul_r1", mul_r1, e_r1);
    chk("mul_r2", mul_r2, e_r2);
  endtask

  task automatic model_step();
    bit kill [N];
    bit rdy  [N];
    bit div_blocked, mul_blocked;
    int win;
    check_outs();
    div_blocked = divide_busy || (last_div == cyc - 1);
    mul_blocked = (busy_run >= DS);
    win = -1;
    for (int j = 0; j < N; j++)
      kill[j] = mv[j] && commit_kill_0[mb[j].rd];
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (win < 0 && mv[j] && !kill[j] &&
          (op_div(mb[j]) ? !div_blocked : !mul_blocked))
        win = j;
    end
    for (int j = 0; j < N; j++) begin
      rdy[j] = !mv[j] || (j == win) || kill[j];
      chk($sformatf("req_ready%0d", j), {63'd0, req_ready[j]},
          {63'd0, rdy[j]});
    end
    if (prev_g) begin
      e_r1 = prev_r1;
      e_r2 = prev_r2;
    end
    prev_g = (win >= 0);
    e_en   = (win >= 0);
    if (win >= 0) begin
      e_op    = mb[win];
      prev_r1 = mb[win].r1;
      prev_r2 = mb[win].r2;
      rr      = (win + 1) % N;
      if (op_div(mb[win])) last_div = cyc;
    end
    for (int j = 0; j < N; j++) begin
      if (req_valid[j] && rdy[j]) begin
        mv[j] = 1;
        mb[j] = '{ctl: req_control[j], rd: req_rd[j],
                  mrd: req_makes_rd[j], hart: req_hart[j],
                  r1: req_r1[j], r2: req_r2[j]};
      end else if (j == win || kill[j]) begin
        mv[j] = 0;
      end
    end
    busy_run = divide_busy ? ((busy_run >= DS) ? DS : busy_run + 1) : 0;
    cyc++;
  endtask

  task automatic drive_random();
    if (busy_left == 0) begin
      divide_busy = ~divide_busy;
      busy_left = divide_busy ? int'($urandom_range(1, 60))
                              : int'($urandom_range(1, 12));
    end
    busy_left--;
    for (int j = 0; j < N; j++) begin
      req_valid[j]    = ($urandom_range(0, 99) < 60);
      req_control[j]  = CS'($urandom);
      req_rd[j]       = LC'($urandom);
      req_makes_rd[j] = 1'($urandom);
      req_hart[j]     = HW'($urandom);
      req_r1[j]       = {$urandom, $urandom};
      req_r2[j]       = {$urandom, $urandom};
    end
    commit_kill_0 = '0;
    if ($urandom_range(0, 9) == 0) begin
      int t;
      t = int'($urandom_range(0, N - 1));
      commit_kill_0[mb[t].rd] = 1'b1;
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    req_valid     = '0;
    req_control   = '0;
    req_rd        = '0;
    req_makes_rd  = '0;
    req_hart      = '0;
    req_r1        = '0;
    req_r2        = '0;
    commit_kill_0 = '0;
    divide_busy   = 1'b0;
    busy_left     = 3;
    model_reset();
    #1;
    chk("rst_enable", {63'd0, mul_enable}, 64'd0);
    chk("rst_ready", {62'd0, req_ready}, 64'd3);
    chk("rst_r1", mul_r1, 64'd0);
    chk("rst_rd", {59'd0, mul_rd}, 64'd0);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (c % 700 == 350) begin
        req_valid = '1;
        reset_n   = 1'b0;
        #1;
        chk("async_rst_enable", {63'd0, mul_enable}, 64'd0);
        chk("async_rst_ready", {62'd0, req_ready}, 64'd3);
        model_reset();
        @(negedge clk);
        check_outs();
        chk("rst_ctl", {57'd0, mul_control}, 64'd0);
        continue;
      end
      reset_n = 1'b1;
      drive_random();
      @(negedge clk);
      model_step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
